cv32e40x_xif_offload_ctrl: RTL



---
 rtl/cv32e40x_pkg.sv | 11 +
 rtl/cv32e40x_xif_offload_scoreboard.sv | 72 +++++++
 rtl/cv32e40x_xif_offload_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cv32e40x_pkg.sv
// cv32e40x_pkg: shared types for the XIF offload controller and its scoreboard
package cv32e40x_pkg;
    localparam int XIF_RFR_WIDTH = 32;
    typedef enum logic [1:0] {XIF_FREE, XIF_ACCEPTED, XIF_COMMITTED} xif_entry_state_e;
    typedef enum logic {XIF_IDLE, XIF_ISSUE} xif_issue_fsm_e;
    typedef struct packed {
        logic [31:0]              instr;
        logic [XIF_RFR_WIDTH-1:0] rs1;
        logic [XIF_RFR_WIDTH-1:0] rs2;
    } offload_packet_t;
endpackage

// File: rtl/cv32e40x_xif_offload_scoreboard.sv
// cv32e40x_xif_offload_scoreboard: per-ID entry states, next issue ID, commit pointer, outstanding count
//   alloc_i            mark next_id ACCEPTED and advance next_id
//   commit_i/kill_i    decide the entry at the commit pointer (kill frees, else COMMITTED)
//   free_i/free_id_i   release a COMMITTED entry after its result
//   lookup_id_i        ID whose COMMITTED status is reported on lookup_committed_o
//   next_id_o, cptr_o  current issue ID and commit pointer
//   cptr_accepted_o    commit pointer entry awaits a core decision
//   room_o             outstanding count below MAX_OUTSTANDING
//   any_busy_o         some entry is not FREE
module cv32e40x_xif_offload_scoreboard import cv32e40x_pkg::*; #(
    parameter int X_ID_WIDTH      = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  alloc_i,
    input  logic                  commit_i,
    input  logic                  kill_i,
    input  logic                  free_i,
    input  logic [X_ID_WIDTH-1:0] free_id_i,
    input  logic [X_ID_WIDTH-1:0] lookup_id_i,
    output logic                  lookup_committed_o,
    output logic [X_ID_WIDTH-1:0] next_id_o,
    output logic [X_ID_WIDTH-1:0] cptr_o,
    output logic                  cptr_accepted_o,
    output logic                  room_o,
    output logic                  any_busy_o
);
    localparam int N  = 2**X_ID_WIDTH;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    xif_entry_state_e      state_q [N];
    xif_entry_state_e      state_d [N];
    logic [X_ID_WIDTH-1:0] next_id_q, next_id_d, cptr_q, cptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    // In legal operation alloc, commit and free always hit distinct IDs
    always_comb begin
        state_d = state_q;
        if (alloc_i) state_d[next_id_q] = XIF_ACCEPTED;
        if (commit_i) state_d[cptr_q] = kill_i ? XIF_FREE : XIF_COMMITTED;
        if (free_i) state_d[free_id_i] = XIF_FREE;
        next_id_d = next_id_q + X_ID_WIDTH'(alloc_i);
        cptr_d    = cptr_q + X_ID_WIDTH'(commit_i);
        cnt_d     = cnt_q + CW'(alloc_i) - CW'(commit_i && kill_i) - CW'(free_i);
    end

    always_comb begin
        any_busy_o = 1'b0;
        for (int i = 0; i < N; i++) any_busy_o = any_busy_o | (state_q[i] != XIF_FREE);
    end

    assign lookup_committed_o = state_q[lookup_id_i] == XIF_COMMITTED;
    assign cptr_accepted_o    = state_q[cptr_q] == XIF_ACCEPTED;
    assign room_o             = cnt_q < CW'(MAX_OUTSTANDING);
    assign next_id_o          = next_id_q;
    assign cptr_o             = cptr_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) state_q[i] <= XIF_FREE;
            next_id_q <= '0;
            cptr_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            next_id_q <= next_id_d;
            cptr_q    <= cptr_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: rtl/cv32e40x_xif_offload_ctrl.sv
// cv32e40x_xif_offload_ctrl: core-side XIF initiator (issue, in-order commit/kill, result writeback)
//   offload_*        core instruction handshake with instruction word and operands
//   issue_*          XIF issue channel, held stable until issue_ready_i
//   core_commit_*    core decision for the oldest uncommitted instruction
//   commit_*         registered single-cycle XIF commit strobe
//   result_*         XIF result channel
//   wb_*             register-file writeback, held until wb_ready_i
//   illegal_o        one-cycle pulse on a rejected issue
//   err_o            sticky flag for a result on a non-COMMITTED ID
//   busy_o           any entry in use or an issue pending
module cv32e40x_xif_offload_ctrl import cv32e40x_pkg::*; #(
    parameter int X_ID_WIDTH      = 4,
    parameter int X_RFR_WIDTH     = XIF_RFR_WIDTH,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    input  logic                   offload_valid_i,
    output logic                   offload_ready_o,
    input  logic [31:0]            offload_instr_i,
    input  logic [X_RFR_WIDTH-1:0] offload_rs1_i,
    input  logic [X_RFR_WIDTH-1:0] offload_rs2_i,
    output logic                   issue_valid_o,
    input  logic                   issue_ready_i,
    output logic [31:0]            issue_instr_o,
    output logic [X_ID_WIDTH-1:0]  issue_id_o,
    output logic [X_RFR_WIDTH-1:0] issue_rs0_o,
    output logic [X_RFR_WIDTH-1:0] issue_rs1_o,
    input  logic                   issue_accept_i,
    input  logic                   core_commit_valid_i,
    input  logic                   core_commit_kill_i,
    output logic                   core_commit_ready_o,
    output logic                   commit_valid_o,
    output logic [X_ID_WIDTH-1:0]  commit_id_o,
    output logic                   commit_kill_o,
    input  logic                   result_valid_i,
    output logic                   result_ready_o,
    input  logic [X_ID_WIDTH-1:0]  result_id_i,
    input  logic [4:0]             result_rd_i,
    input  logic [X_RFR_WIDTH-1:0] result_data_i,
    input  logic                   result_we_i,
    output logic                   wb_valid_o,
    input  logic                   wb_ready_i,
    output logic [4:0]             wb_rd_o,
    output logic [X_RFR_WIDTH-1:0] wb_data_o,
    output logic                   illegal_o,
    output logic                   err_o,
    output logic                   busy_o
);
    xif_issue_fsm_e        fsm_q, fsm_d;
    offload_packet_t       pkt_q, pkt_d;
    logic                  illegal_q, illegal_d, err_q, err_d, wb_valid_q, wb_valid_d;
    logic                  commit_valid_q, commit_valid_d, commit_kill_q, commit_kill_d;
    logic [X_ID_WIDTH-1:0] commit_id_q, commit_id_d, next_id, cptr;
    logic [4:0]            wb_rd_q, wb_rd_d;
    logic [X_RFR_WIDTH-1:0] wb_data_q, wb_data_d;
    logic                  room, cptr_accepted, lookup_committed, any_busy;
    logic                  offload_hs, issue_hs, commit_fire, result_hs, result_ok, wb_load;

    cv32e40x_xif_offload_scoreboard #(
        .X_ID_WIDTH      (X_ID_WIDTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_sb (
        .clk_i              (clk_i),
        .rst_n              (rst_n),
        .alloc_i            (issue_hs && issue_accept_i),
        .commit_i           (commit_fire),
        .kill_i             (core_commit_kill_i),
        .free_i             (result_ok),
        .free_id_i          (result_id_i),
        .lookup_id_i        (result_id_i),
        .lookup_committed_o (lookup_committed),
        .next_id_o          (next_id),
        .cptr_o             (cptr),
        .cptr_accepted_o    (cptr_accepted),
        .room_o             (room),
        .any_busy_o         (any_busy)
    );

    always_comb begin
        issue_valid_o   = fsm_q == XIF_ISSUE;
        offload_ready_o = (fsm_q == XIF_IDLE) && room;
    end

    always_comb begin
        fsm_d = fsm_q == XIF_IDLE ? (offload_hs ? XIF_ISSUE : XIF_IDLE) : (issue_ready_i ? XIF_IDLE : XIF_ISSUE);
    end

    assign offload_hs  = offload_valid_i && offload_ready_o;
    assign issue_hs    = issue_valid_o && issue_ready_i;
    assign commit_fire = core_commit_valid_i && cptr_accepted;
    assign result_hs   = result_valid_i && result_ready_o;
    assign result_ok   = result_hs && lookup_committed;
    assign wb_load     = result_ok && result_we_i;

    always_comb begin
        pkt_d          = offload_hs ? offload_packet_t'({offload_instr_i, offload_rs1_i, offload_rs2_i}) : pkt_q;
        illegal_d      = issue_hs && !issue_accept_i;
        commit_valid_d = commit_fire;
        commit_id_d    = commit_fire ? cptr : commit_id_q;
        commit_kill_d  = commit_fire ? core_commit_kill_i : commit_kill_q;
        err_d          = err_q || (result_hs && !lookup_committed);
        wb_valid_d     = wb_load || (wb_valid_q && !wb_ready_i);
        wb_rd_d        = wb_load ? result_rd_i : wb_rd_q;
        wb_data_d      = wb_load ? result_data_i : wb_data_q;
    end

    assign issue_instr_o       = pkt_q.instr;
    assign issue_rs0_o         = pkt_q.rs1;
    assign issue_rs1_o         = pkt_q.rs2;
    assign issue_id_o          = next_id;
    assign core_commit_ready_o = cptr_accepted;
    assign commit_valid_o      = commit_valid_q;
    assign commit_id_o         = commit_id_q;
    assign commit_kill_o       = commit_kill_q;
    assign result_ready_o      = !wb_valid_q || wb_ready_i;
    assign wb_valid_o          = wb_valid_q;
    assign wb_rd_o             = wb_rd_q;
    assign wb_data_o           = wb_data_q;
    assign illegal_o           = illegal_q;
    assign err_o               = err_q;
    assign busy_o              = any_busy || (fsm_q != XIF_IDLE);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q          <= XIF_IDLE;
            pkt_q          <= '0;
            illegal_q      <= 1'b0;
            err_q          <= 1'b0;
            commit_valid_q <= 1'b0;
            commit_id_q    <= '0;
            commit_kill_q  <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
        end else begin
            fsm_q          <= fsm_d;
            pkt_q          <= pkt_d;
            illegal_q      <= illegal_d;
            err_q          <= err_d;
            commit_valid_q <= commit_valid_d;
            commit_id_q    <= commit_id_d;
            commit_kill_q  <= commit_kill_d;
            wb_valid_q     <= wb_valid_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
        end
    end
endmodule
